// File: rtl/pll_reset_sequencer.sv
// Sequences PLL reset and lock qualification, then releases a synchronous system
// reset and generates two divided clock-enable strobes while the PLL stays locked.
module pll_reset_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int STABLE_CYCLES  = 1024,
  parameter int CEN_DIV_A      = 8,
  parameter int CEN_DIV_B      = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       locked,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       cen_a,
  output logic       cen_b,
  output logic [1:0] state,
  output logic [3:0] retries,
  output logic       lock_lost
);

  localparam int MAX_A   = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CNT = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
  localparam int CW      = $clog2(MAX_CNT);
  localparam int AW      = $clog2(CEN_DIV_A);
  localparam int BW      = $clog2(CEN_DIV_B);

  localparam logic [CW-1:0] PLL_LAST    = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [AW-1:0] A_LAST      = AW'(CEN_DIV_A - 1);
  localparam logic [AW-1:0] A_FIRE      = AW'(CEN_DIV_A - 2);
  localparam logic [BW-1:0] B_LAST      = BW'(CEN_DIV_B - 1);
  localparam logic [BW-1:0] B_FIRE      = BW'(CEN_DIV_B - 2);

  typedef enum logic [1:0] {
    S_PLL_RST   = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_STABLE    = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  state_t                 state_reg;
  logic [CW-1:0]          cnt_reg;
  logic [AW-1:0]          div_a_reg;
  logic [BW-1:0]          div_b_reg;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   locked_s;

  assign state    = state_reg;
  assign locked_s = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_reg <= '0;
    else     sync_reg <= {sync_reg[SYNC_STAGES-2:0], locked};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_PLL_RST;
      cnt_reg   <= '0;
      div_a_reg <= '0;
      div_b_reg <= '0;
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      cen_a     <= 1'b0;
      cen_b     <= 1'b0;
      retries   <= 4'd0;
      lock_lost <= 1'b0;
    end else begin
      // Strobes and dividers idle unless the RUN branch below drives them.
      cen_a     <= 1'b0;
      cen_b     <= 1'b0;
      div_a_reg <= '0;
      div_b_reg <= '0;
      case (state_reg)
        S_PLL_RST: begin
          pll_rst <= 1'b1;
          sys_rst <= 1'b1;
          if (cnt_reg == PLL_LAST) begin
            state_reg <= S_WAIT_LOCK;
            pll_rst   <= 1'b0;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        S_WAIT_LOCK: begin
          if (locked_s) begin
            state_reg <= S_STABLE;
            cnt_reg   <= '0;
          end else if (cnt_reg == LOCK_LAST) begin
            state_reg <= S_PLL_RST;
            pll_rst   <= 1'b1;
            cnt_reg   <= '0;
            if (retries != 4'hF) retries <= retries + 4'd1;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        S_STABLE: begin
          if (!locked_s) begin
            state_reg <= S_WAIT_LOCK;
            cnt_reg   <= '0;
          end else if (cnt_reg == STABLE_LAST) begin
            state_reg <= S_RUN;
            sys_rst   <= 1'b0;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        S_RUN: begin
          // Lock loss wins over any strobe due on this edge; the PLL is left alone.
          if (!locked_s) begin
            state_reg <= S_WAIT_LOCK;
            sys_rst   <= 1'b1;
            lock_lost <= 1'b1;
            cnt_reg   <= '0;
          end else begin
            div_a_reg <= (div_a_reg == A_LAST) ? '0 : div_a_reg + AW'(1);
            div_b_reg <= (div_b_reg == B_LAST) ? '0 : div_b_reg + BW'(1);
            cen_a     <= (div_a_reg == A_FIRE);
            cen_b     <= (div_b_reg == B_FIRE);
          end
        end
        default: state_reg <= S_PLL_RST;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with short timing parameters; each task
// drives one scenario and compares outputs against hand-derived edge schedules.
module tb_pll_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       locked = 1'b0;
  logic       pll_rst, sys_rst, cen_a, cen_b, lock_lost;
  logic [1:0] state;
  logic [3:0] retries;

  int n_cmp = 0;
  int n_bad = 0;

  pll_reset_sequencer #(
    .SYNC_STAGES(2), .PLL_RST_CYCLES(4), .LOCK_TIMEOUT(32),
    .STABLE_CYCLES(8), .CEN_DIV_A(8), .CEN_DIV_B(12)
  ) dut (
    .clk(clk), .rst(rst), .locked(locked),
    .pll_rst(pll_rst), .sys_rst(sys_rst), .cen_a(cen_a), .cen_b(cen_b),
    .state(state), .retries(retries), .lock_lost(lock_lost)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  // Leaves the bench at a falling edge with zero rising edges since rst release.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Advance one rising edge and return to the following falling edge for sampling.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (pll_rst !== 1'b1)   begin n_bad++; $display("FAIL reset_pll_rst got %b want 1", pll_rst); end
    n_cmp++; if (sys_rst !== 1'b1)   begin n_bad++; $display("FAIL reset_sys_rst got %b want 1", sys_rst); end
    n_cmp++; if (cen_a !== 1'b0)     begin n_bad++; $display("FAIL reset_cen_a got %b want 0", cen_a); end
    n_cmp++; if (cen_b !== 1'b0)     begin n_bad++; $display("FAIL reset_cen_b got %b want 0", cen_b); end
    n_cmp++; if (state !== 2'd0)     begin n_bad++; $display("FAIL reset_state got %0d want 0", state); end
    n_cmp++; if (retries !== 4'd0)   begin n_bad++; $display("FAIL reset_retries got %0d want 0", retries); end
    n_cmp++; if (lock_lost !== 1'b0) begin n_bad++; $display("FAIL reset_lock_lost got %b want 0", lock_lost); end
    $display("test_reset: outputs checked while rst held");
  endtask

  task automatic test_normal_start();
    logic       ep, es;
    logic [1:0] est;
    locked = 1'b1;
    do_reset();
    for (int e = 1; e <= 13; e++) begin
      step();
      ep  = (e < 4);
      es  = (e < 13);
      est = (e < 4) ? 2'd0 : (e == 4) ? 2'd1 : (e < 13) ? 2'd2 : 2'd3;
      n_cmp++; if (pll_rst !== ep) begin n_bad++; $display("FAIL start_pll_rst edge %0d got %b want %b", e, pll_rst, ep); end
      n_cmp++; if (sys_rst !== es) begin n_bad++; $display("FAIL start_sys_rst edge %0d got %b want %b", e, sys_rst, es); end
      n_cmp++; if (state !== est)  begin n_bad++; $display("FAIL start_state edge %0d got %0d want %0d", e, state, est); end
    end
    n_cmp++; if (retries !== 4'd0) begin n_bad++; $display("FAIL start_retries got %0d want 0", retries); end
    $display("test_normal_start: 13 edges checked");
  endtask

  task automatic test_no_lock();
    logic       ep;
    logic [1:0] est;
    logic [3:0] er;
    locked = 1'b0;
    do_reset();
    for (int e = 1; e <= 620; e++) begin
      step();
      ep  = ((e % 36) < 4);
      est = ep ? 2'd0 : 2'd1;
      er  = (e / 36 > 15) ? 4'd15 : 4'(e / 36);
      n_cmp++; if (pll_rst !== ep)   begin n_bad++; $display("FAIL nolock_pll_rst edge %0d got %b want %b", e, pll_rst, ep); end
      n_cmp++; if (state !== est)    begin n_bad++; $display("FAIL nolock_state edge %0d got %0d want %0d", e, state, est); end
      n_cmp++; if (retries !== er)   begin n_bad++; $display("FAIL nolock_retries edge %0d got %0d want %0d", e, retries, er); end
      n_cmp++; if (sys_rst !== 1'b1) begin n_bad++; $display("FAIL nolock_sys_rst edge %0d got %b want 1", e, sys_rst); end
    end
    // Saturated retry count must clear asynchronously.
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (retries !== 4'd0) begin n_bad++; $display("FAIL nolock_retries_clear got %0d want 0", retries); end
    rst = 1'b0;
    $display("test_no_lock: 620 edges checked, retries saturate at 15");
  endtask

  task automatic test_stable_glitch();
    logic       es;
    logic [1:0] est;
    do_reset();
    for (int e = 1; e <= 22; e++) begin
      locked = !(e >= 9 && e <= 11);
      step();
      es  = (e < 22);
      est = (e < 4) ? 2'd0 : (e == 4) ? 2'd1 : (e <= 10) ? 2'd2 :
            (e <= 13) ? 2'd1 : (e <= 21) ? 2'd2 : 2'd3;
      n_cmp++; if (sys_rst !== es)   begin n_bad++; $display("FAIL glitch_sys_rst edge %0d got %b want %b", e, sys_rst, es); end
      n_cmp++; if (state !== est)    begin n_bad++; $display("FAIL glitch_state edge %0d got %0d want %0d", e, state, est); end
      n_cmp++; if (retries !== 4'd0) begin n_bad++; $display("FAIL glitch_retries edge %0d got %0d want 0", e, retries); end
    end
    $display("test_stable_glitch: release after edge 22 checked");
  endtask

  task automatic test_enables();
    int         na, nb, nboth;
    logic       ea, eb;
    locked = 1'b1;
    do_reset();
    repeat (13) step();
    na = 0; nb = 0; nboth = 0;
    for (int c = 1; c <= 96; c++) begin
      ea = ((c % 8) == 0);
      eb = ((c % 12) == 0);
      n_cmp++; if (cen_a !== ea) begin n_bad++; $display("FAIL cen_a run cycle %0d got %b want %b", c, cen_a, ea); end
      n_cmp++; if (cen_b !== eb) begin n_bad++; $display("FAIL cen_b run cycle %0d got %b want %b", c, cen_b, eb); end
      if (cen_a === 1'b1) na++;
      if (cen_b === 1'b1) nb++;
      if (cen_a === 1'b1 && cen_b === 1'b1) nboth++;
      step();
    end
    n_cmp++; if (na != 12)   begin n_bad++; $display("FAIL cen_a_count got %0d want 12", na); end
    n_cmp++; if (nb != 8)    begin n_bad++; $display("FAIL cen_b_count got %0d want 8", nb); end
    n_cmp++; if (nboth != 4) begin n_bad++; $display("FAIL cen_coincide got %0d want 4", nboth); end
    $display("test_enables: 96 run cycles, cen_a=%0d cen_b=%0d both=%0d", na, nb, nboth);
  endtask

  // Lock pin low before edges 26..28; the drop lands on edge 28 where cen_a was due.
  task automatic test_lock_loss();
    logic       es, ep, el, ea, eb;
    logic [1:0] est;
    locked = 1'b1;
    do_reset();
    for (int e = 1; e <= 47; e++) begin
      locked = !(e >= 26 && e <= 28);
      step();
      ep  = (e < 4);
      es  = (e < 13) || (e >= 28 && e < 39);
      el  = (e >= 28);
      ea  = (e == 20) || (e == 46);
      eb  = (e == 24);
      est = (e < 4) ? 2'd0 : (e == 4) ? 2'd1 : (e < 13) ? 2'd2 : (e < 28) ? 2'd3 :
            (e < 31) ? 2'd1 : (e < 39) ? 2'd2 : 2'd3;
      n_cmp++; if (pll_rst !== ep)   begin n_bad++; $display("FAIL loss_pll_rst edge %0d got %b want %b", e, pll_rst, ep); end
      n_cmp++; if (sys_rst !== es)   begin n_bad++; $display("FAIL loss_sys_rst edge %0d got %b want %b", e, sys_rst, es); end
      n_cmp++; if (lock_lost !== el) begin n_bad++; $display("FAIL loss_lock_lost edge %0d got %b want %b", e, lock_lost, el); end
      n_cmp++; if (state !== est)    begin n_bad++; $display("FAIL loss_state edge %0d got %0d want %0d", e, state, est); end
      n_cmp++; if (cen_a !== ea)     begin n_bad++; $display("FAIL loss_cen_a edge %0d got %b want %b", e, cen_a, ea); end
      n_cmp++; if (cen_b !== eb)     begin n_bad++; $display("FAIL loss_cen_b edge %0d got %b want %b", e, cen_b, eb); end
    end
    $display("test_lock_loss: 47 edges checked, lock_lost sticky");
  endtask

  // Entered from RUN with lock_lost set by the previous task.
  task automatic test_async_reset();
    logic       ep, es;
    logic [1:0] est;
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (pll_rst !== 1'b1)   begin n_bad++; $display("FAIL async_pll_rst got %b want 1", pll_rst); end
    n_cmp++; if (sys_rst !== 1'b1)   begin n_bad++; $display("FAIL async_sys_rst got %b want 1", sys_rst); end
    n_cmp++; if (lock_lost !== 1'b0) begin n_bad++; $display("FAIL async_lock_lost got %b want 0", lock_lost); end
    n_cmp++; if (retries !== 4'd0)   begin n_bad++; $display("FAIL async_retries got %0d want 0", retries); end
    n_cmp++; if (state !== 2'd0)     begin n_bad++; $display("FAIL async_state got %0d want 0", state); end
    n_cmp++; if (cen_a !== 1'b0 || cen_b !== 1'b0) begin
      n_bad++; $display("FAIL async_cen got %b%b want 00", cen_a, cen_b);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int e = 1; e <= 13; e++) begin
      step();
      ep  = (e < 4);
      es  = (e < 13);
      est = (e < 4) ? 2'd0 : (e == 4) ? 2'd1 : (e < 13) ? 2'd2 : 2'd3;
      n_cmp++; if (pll_rst !== ep) begin n_bad++; $display("FAIL restart_pll_rst edge %0d got %b want %b", e, pll_rst, ep); end
      n_cmp++; if (sys_rst !== es) begin n_bad++; $display("FAIL restart_sys_rst edge %0d got %b want %b", e, sys_rst, es); end
      n_cmp++; if (state !== est)  begin n_bad++; $display("FAIL restart_state edge %0d got %0d want %0d", e, state, est); end
    end
    $display("test_async_reset: mid-RUN reset and restart timing checked");
  endtask

  initial begin
    test_reset();
    test_normal_start();
    test_no_lock();
    test_stable_glitch();
    test_enables();
    test_lock_loss();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Consumer end of the clock PLL interface: drives the PLL's `rst` request and monitors its asynchronous `locked` output.
- Produces a clean synchronous system reset and two clock-enable strobes for the game core, all in the PLL output clock domain.
- Re-pulses the PLL reset if lock is not achieved within a timeout.
- Re-asserts system reset immediately if lock is lost while running.

Parameters:
- SYNC_STAGES, 2: flops in the `locked` synchroniser (≥2).
- PLL_RST_CYCLES, 16: cycles `pll_rst` is held high per attempt (≥2).
- LOCK_TIMEOUT, 65536: cycles to wait for lock before re-resetting the PLL (≥2).
- STABLE_CYCLES, 1024: cycles `locked` must stay high continuously before release (≥2).
- CEN_DIV_A, 8: divide ratio for `cen_a` (48 MHz → 6 MHz) (≥2).
- CEN_DIV_B, 12: divide ratio for `cen_b` (48 MHz → 4 MHz) (≥2).

Ports:
- clk  in  1  PLL output clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- locked  in  1  PLL lock indicator; asynchronous to clk.
- pll_rst  out  1  reset request to the PLL, active-high.
- sys_rst  out  1  synchronous system reset, active-high.
- cen_a  out  1  one-cycle clock-enable strobe, period CEN_DIV_A.
- cen_b  out  1  one-cycle clock-enable strobe, period CEN_DIV_B.
- state  out  2  0=PLL_RST, 1=WAIT_LOCK, 2=STABLE, 3=RUN.
- retries  out  4  count of lock timeouts, saturating at 15.
- lock_lost  out  1  sticky flag: lock dropped while in RUN.

Behaviour:
- Reset (async, no clock needed) forces: pll_rst=1, sys_rst=1, cen_a=0, cen_b=0, state=PLL_RST, retries=0, lock_lost=0, all counters and synchroniser flops cleared.
- All outputs are registered.
- `locked` passes through SYNC_STAGES flops to give locked_s; locked_s is the only form of `locked` used.
- PLL_RST:
  - pll_rst=1; the counter runs 0..PLL_RST_CYCLES-1.
  - On the edge where the counter equals PLL_RST_CYCLES-1: go to WAIT_LOCK, pll_rst=0, counter cleared.
  - locked_s is ignored in this state.
- WAIT_LOCK:
  - If locked_s=1: go to STABLE, counter cleared.
  - Else, if the counter equals LOCK_TIMEOUT-1: go to PLL_RST, counter cleared, retries+1 (saturating at 15).
  - Else: counter+1.
- STABLE:
  - If locked_s=0: go to WAIT_LOCK, counter cleared; retries is unchanged.
  - Else, if the counter equals STABLE_CYCLES-1: go to RUN, sys_rst=0 on the same edge.
  - Else: counter+1.
- RUN:
  - sys_rst=0. Divider counters A and B are cleared on entry and free-run.
  - cen_a is high for exactly one cycle in every CEN_DIV_A. Its first high cycle is the CEN_DIV_A-th cycle with sys_rst low.
  - cen_b follows the same rule with CEN_DIV_B.
  - If locked_s=0: on the next edge sys_rst=1, cen_a=0, cen_b=0, lock_lost=1, state=WAIT_LOCK. The PLL is not reset.
  - Lock loss takes precedence over a cen pulse scheduled for the same edge.
- Outside RUN: cen_a=cen_b=0 and the divider counters are held at 0.
- lock_lost clears only on rst.
- Latency from a `locked` pin fall (in RUN) to sys_rst=1 is SYNC_STAGES+1 clk edges.
- The counter width is sized for the maximum of PLL_RST_CYCLES, LOCK_TIMEOUT and STABLE_CYCLES. It never wraps, because every state exits at its terminal count.
- rst asserted mid-operation, including mid-RUN or mid-pll_rst, immediately applies the reset values above. The sequence then restarts from PLL_RST.

Test Plan:
Bench parameters: SYNC_STAGES=2, PLL_RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, CEN_DIV_A=8, CEN_DIV_B=12. Edges are counted from the rst release.
- Normal start, `locked` tied 1: pll_rst falls after edge 4; state=STABLE after edge 5; sys_rst falls after edge 13; state=3; retries=0.
- `locked` held 0: pll_rst re-pulses high for 4 cycles every 36 cycles; retries counts 1, 2, … up to 15 and stays 15; sys_rst stays 1 throughout.
- Lock glitch in STABLE (`locked` low for 3 cycles midway): state returns to WAIT_LOCK, then STABLE re-entered with the counter cleared; sys_rst stays 1; retries stays 0; release occurs a full 8 cycles after locked_s returns high.
- Enables over 96 cycles of RUN:
  - cen_a gives 12 one-cycle pulses exactly 8 apart, the first on RUN cycle 8.
  - cen_b gives 8 pulses exactly 12 apart, the first on RUN cycle 12.
  - The two pulses coincide every 24 cycles.
- Lock loss in RUN:
  - `locked` pin falls → sys_rst=1, cen_a=cen_b=0 and lock_lost=1 after edge 3.
  - When `locked` returns, sys_rst falls again 8 cycles after re-entering STABLE; lock_lost remains 1; pll_rst is never pulsed.
- Async reset mid-RUN: rst asserted between clock edges → pll_rst=1, sys_rst=1, lock_lost=0, retries=0, state=0 with no clk edge; after release the normal start timing repeats exactly.
